setbr: RTL and testbench
========================

SETBR -- requirements
Module: setbr

Interface
REQ-001 SHALL have parameter CHUNK, default 8: bits written per EXEC cycle. Legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1 bit: operation request, sampled in IDLE only.
REQ-005 SHALL have port rs0_i, input, 32 bits: source word.
REQ-006 SHALL have port rs1_i, input, 32 bits: start bit position; only bits [4:0] are used.
REQ-007 SHALL have port rs2_i, input, 32 bits: run length; only bits [5:0] are used; values above 32 saturate to 32.
REQ-008 SHALL have port val_i, input, 1 bit: value of the bits written into the run.
REQ-009 SHALL have port rd_o, output, 32 bits: result word.
REQ-010 SHALL have port cnt_o, output, 6 bits: number of bits actually written.
REQ-011 SHALL have port busy_o, output, 1 bit: high in EXEC and DONE.
REQ-012 SHALL have port setbr_done_o, output, 1 bit: one-cycle completion strobe.

Function
REQ-013 SHALL perform the inverse of the consecutive-bit counter.
- Writes a run of val_i bits into rs0_i.
- Run starts at bit pos = rs1_i[4:0] and extends toward bit 0.
REQ-014 SHALL compute eff = min(len, pos+1), with len the saturated rs2_i; the run covers bits pos down to pos-eff+1.
REQ-015 SHALL leave every bit outside the run equal to rs0_i.
REQ-016 SHALL use the FSM states IDLE, EXEC and DONE; the reset state is IDLE.
REQ-017 SHALL, in IDLE with start_i=1, capture rs0_i, pos, eff and val_i into internal registers and move to EXEC on the next edge.
- Inputs may change freely after the capture.
REQ-018 SHALL, in each EXEC cycle, write min(CHUNK, remaining) bits of the working word.
- Starts at the current cursor, moving toward bit 0.
- Decrements remaining by the same amount.
- Moves the cursor down by the same amount.
REQ-019 SHALL leave EXEC for DONE after the cycle in which remaining reaches 0.
- eff=0 spends exactly one EXEC cycle writing nothing.
REQ-020 SHALL take EXEC cycle count N = max(1, ceil(eff/CHUNK)).
- Start accepted at edge T gives setbr_done_o=1 during cycle T+1+N.
REQ-021 SHALL assert setbr_done_o only in DONE, for exactly one cycle, then return to IDLE.
REQ-022 SHALL drive rd_o and cnt_o from registers.
- Both are updated at entry to DONE (cnt_o=eff).
- Both hold until the next DONE entry or reset.
REQ-023 SHALL ignore start_i in EXEC and DONE; there is no queuing, and a start in DONE is lost.
REQ-024 SHALL use no arithmetic wider than 6 bits for counters.
- The cursor never wraps below bit 0: eff clipping guarantees this.

Reset
REQ-025 SHALL, while rst_i=1, asynchronously force:
- state to IDLE;
- rd_o=0, cnt_o=0, busy_o=0, setbr_done_o=0;
- all internal registers to 0.
REQ-026 SHALL abort an operation in progress when reset is asserted mid-EXEC or mid-DONE.
- No done strobe is produced.
- The first start after reset release behaves as from power-up.

Verification
REQ-027 SHALL cover: rs0=0x00000000, rs1=31, rs2=8, val=1, start at T -> done at T+2, rd=0xFF000000, cnt=8.
REQ-028 SHALL cover: rs0=0xFFFFFFFF, rs1=15, rs2=12, val=0 -> N=2, done at T+3, rd=0xFFFF000F, cnt=12.
REQ-029 SHALL cover: rs0=0x00000000, rs1=3, rs2=10, val=1 -> clipped, rd=0x0000000F, cnt=4, done at T+2.
REQ-030 SHALL cover: rs0=0x12345678, rs2=0 -> rd=0x12345678, cnt=0, done at T+2.
REQ-031 SHALL cover: rs0=0, rs1=31, rs2=63, val=1 -> saturation to 32, N=4, done at T+5, rd=0xFFFFFFFF, cnt=32.
- Extra start pulses at T+1..T+5 are ignored.
- Input changes after T do not alter the result.
REQ-032 SHALL cover: rst_i pulsed during the 2nd EXEC cycle of REQ-031's stimulus -> no done strobe; outputs and busy_o are 0 immediately.
- A following REQ-027 stimulus completes correctly.

Source files
------------

// File: rtl/setbr.sv
// rtl/setbr.sv - multi-cycle bit-run writer, inverse of the consecutive-bit counter
module setbr #(
    parameter int CHUNK = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] rs0_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        val_i,
    output logic [31:0] rd_o,
    output logic [5:0]  cnt_o,
    output logic        busy_o,
    output logic        setbr_done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] CH = 6'(CHUNK);

    state_t      state_q, state_d;
    logic [31:0] work_q;
    logic [5:0]  top_q;     // one above the next bit to write, so it bottoms out at 0
    logic [5:0]  remain_q;
    logic [5:0]  eff_q;
    logic        val_q;

    logic [5:0]  len_sat;
    logic [5:0]  top_init;
    logic [5:0]  eff_init;
    logic [5:0]  step;
    logic [5:0]  low;
    logic [31:0] mask;
    logic [31:0] work_next;
    logic        last_step;

    // Operand decode at capture: saturate length, clip to the bits available below pos
    always_comb begin
        len_sat  = (rs2_i[5:0] > 6'd32) ? 6'd32 : rs2_i[5:0];
        top_init = {1'b0, rs1_i[4:0]} + 6'd1;
        eff_init = (len_sat < top_init) ? len_sat : top_init;
    end

    // Per-cycle slice: bits [top-step, top-1] of the working word get val
    always_comb begin
        step      = (remain_q > CH) ? CH : remain_q;
        low       = top_q - step;
        last_step = (remain_q <= CH);
        mask      = '0;
        for (int i = 0; i < 32; i++) begin
            mask[i] = (6'(i) < top_q) && (6'(i) >= low);
        end
        work_next = val_q ? (work_q | mask) : (work_q & ~mask);
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_d      = state_q;
        busy_o       = 1'b0;
        setbr_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = EXEC;
            end
            EXEC: begin
                busy_o = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                busy_o       = 1'b1;
                setbr_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands, write one chunk per EXEC cycle, publish on DONE entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work_q   <= '0;
            top_q    <= '0;
            remain_q <= '0;
            eff_q    <= '0;
            val_q    <= 1'b0;
            rd_o     <= '0;
            cnt_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        work_q   <= rs0_i;
                        top_q    <= top_init;
                        remain_q <= eff_init;
                        eff_q    <= eff_init;
                        val_q    <= val_i;
                    end
                end
                EXEC: begin
                    work_q   <= work_next;
                    top_q    <= low;
                    remain_q <= remain_q - step;
                    if (last_step) begin
                        rd_o  <= work_next;
                        cnt_o <= eff_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_setbr.sv
// tb/tb_setbr.sv - scoreboard bench for setbr
module tb_setbr;

    localparam int CHUNK = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] rs0_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        val_i = 1'b0;
    logic [31:0] rd_o;
    logic [5:0]  cnt_o;
    logic        busy_o;
    logic        setbr_done_o;

    typedef struct {
        logic [31:0] rd;
        logic [5:0]  cnt;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    setbr #(.CHUNK(CHUNK)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .rs0_i        (rs0_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .val_i        (val_i),
        .rd_o         (rd_o),
        .cnt_o        (cnt_o),
        .busy_o       (busy_o),
        .setbr_done_o (setbr_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: walk the run bit by bit from pos downward
    task automatic push_expect(input logic [31:0] rs0, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic val);
        exp_t e;
        int   pos, len, eff;
        pos = int'(rs1[4:0]);
        len = int'(rs2[5:0]);
        if (len > 32) len = 32;
        eff = (len < pos + 1) ? len : pos + 1;
        e.rd = rs0;
        for (int k = 0; k < eff; k++) e.rd[pos - k] = val;
        e.cnt = 6'(eff);
        e.lat = (eff == 0) ? 1 : (eff + CHUNK - 1) / CHUNK;
        exp_q.push_back(e);
    endtask

    // Drive one operation; with noisy set, start stays high and inputs churn after capture
    task automatic run_op(input string tag, input logic [31:0] rs0, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic val, input bit noisy);
        exp_t e;
        int   edges;
        bit   seen;
        @(negedge clk_i);
        rs0_i = rs0; rs1_i = rs1; rs2_i = rs2; val_i = val; start_i = 1'b1;
        push_expect(rs0, rs1, rs2, val);
        @(posedge clk_i);
        #1;
        if (noisy) begin
            rs0_i = 32'hA5A5_5A5A; rs1_i = 32'd3; rs2_i = 32'd1; val_i = ~val;
        end else begin
            start_i = 1'b0;
        end
        check({tag, ".busy_exec"}, 32'(busy_o), 32'd1);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk_i);
            #1;
            edges++;
            if (setbr_done_o) seen = 1'b1;
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            e = exp_q.pop_front();
            check({tag, ".latency"}, 32'(edges), 32'(e.lat));
            check({tag, ".rd"}, rd_o, e.rd);
            check({tag, ".cnt"}, 32'(cnt_o), 32'(e.cnt));
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            check({tag, ".done_pulse"}, 32'(setbr_done_o), 32'd0);
            check({tag, ".busy_idle"}, 32'(busy_o), 32'd0);
            check({tag, ".rd_hold"}, rd_o, e.rd);
        end else begin
            void'(exp_q.pop_front());
            start_i = 1'b0;
        end
    endtask

    initial begin
        int  edges;
        bit  seen;
        #1;
        check("reset.rd", rd_o, 32'd0);
        check("reset.cnt", 32'(cnt_o), 32'd0);
        check("reset.busy", 32'(busy_o), 32'd0);
        check("reset.done", 32'(setbr_done_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op("run_top8",  32'h0000_0000, 32'd31, 32'd8,  1'b1, 1'b0);
        run_op("clear12",   32'hFFFF_FFFF, 32'd15, 32'd12, 1'b0, 1'b0);
        run_op("clip",      32'h0000_0000, 32'd3,  32'd10, 1'b1, 1'b0);
        run_op("len0",      32'h1234_5678, 32'd9,  32'd0,  1'b1, 1'b0);
        run_op("sat32",     32'h0000_0000, 32'd31, 32'd63, 1'b1, 1'b1);
        run_op("bit0",      32'hFFFF_FFFE, 32'd0,  32'd5,  1'b1, 1'b0);
        run_op("hi_bits",   32'hDEAD_BEEF, 32'hFFFF_FFF0, 32'hFFFF_FF11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op("random", $urandom, $urandom, 32'($urandom_range(0, 63)), 1'($urandom), 1'b0);
        end

        // Reset asserted in the second EXEC cycle of a saturated run
        @(negedge clk_i);
        rs0_i = 32'h0; rs1_i = 32'd31; rs2_i = 32'd63; val_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("abort.rd", rd_o, 32'd0);
        check("abort.cnt", 32'(cnt_o), 32'd0);
        check("abort.busy", 32'(busy_o), 32'd0);
        check("abort.done", 32'(setbr_done_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 1'b0;
        for (edges = 0; edges < 8; edges++) begin
            @(posedge clk_i);
            #1;
            if (setbr_done_o || busy_o) seen = 1'b1;
        end
        check("abort.quiet", 32'(seen), 32'd0);
        run_op("after_rst", 32'h0000_0000, 32'd31, 32'd8, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
